// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants,
// common to the transmitter and the future receiver.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_param_if.sv
// Client-side handshake of the UART transmitter: word request in, status and
// serial line out.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 en;
  logic                 start;
  logic [DATA_BITS-1:0] data_in;
  logic                 busy;
  logic                 done;
  logic                 out;

  modport master (
    output en,
    output start,
    output data_in,
    input  busy,
    input  done,
    input  out
  );

  modport slave (
    input  en,
    input  start,
    input  data_in,
    output busy,
    output done,
    output out
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final count, so the owner advances exactly once per serial bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional
// parity, 1 or 2 stop bits; back-to-back frames and abort on enable drop.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_param_if.slave  tx
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_t               state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 done_q;
  logic                 tick;
  logic                 tick_clr;
  logic                 tick_en;
  logic                 last_stop;
  logic                 accept;
  logic                 line;

  // Rotation keeps the XOR of the register equal to the latched word.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ PAR_MODE;
  endfunction

  assign last_stop = (state == ST_STOP) && tick && (bit_idx == LAST_STOP);
  assign accept    = tx.en && tx.start && ((state == ST_IDLE) || last_stop);
  assign tick_clr  = accept || !tx.en;
  assign tick_en   = (state != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!tx.en) begin
        state   <= ST_IDLE;
        bit_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) state <= ST_START;
          end
          ST_START: begin
            if (tick) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (bit_idx == LAST_DATA) begin
                bit_idx <= '0;
                state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (tick) begin
              state   <= ST_STOP;
              bit_idx <= '0;
            end
          end
          ST_STOP: begin
            if (tick) begin
              if (bit_idx == LAST_STOP) begin
                bit_idx <= '0;
                done_q  <= 1'b1;
                state   <= accept ? ST_START : ST_IDLE;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

  // Data register carries no reset; the FSM alone decides when it is shown.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= tx.data_in;
    end else if ((state == ST_DATA) && tick) begin
      shreg <= {shreg[0], shreg[DATA_BITS-1:1]};
    end
  end

  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shreg[0];
      ST_PARITY: line = parity_of(shreg);
      default:   line = 1'b1;
    endcase
  end

  assign tx.out  = line;
  assign tx.busy = (state != ST_IDLE);
  assign tx.done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations at CLKS_PER_BIT=4,
// frames captured cycle by cycle and compared against hand-derived bit patterns.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_v    [4];
  logic       start_v [4];
  logic [8:0] data_v  [4];
  logic       out_w   [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.en = en_v[0];  assign if0.start = start_v[0];  assign if0.data_in = data_v[0][7:0];
  assign if1.en = en_v[1];  assign if1.start = start_v[1];  assign if1.data_in = data_v[1][7:0];
  assign if2.en = en_v[2];  assign if2.start = start_v[2];  assign if2.data_in = data_v[2][7:0];
  assign if3.en = en_v[3];  assign if3.start = start_v[3];  assign if3.data_in = data_v[3][6:0];

  assign out_w[0] = if0.out;  assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done;
  assign out_w[1] = if1.out;  assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done;
  assign out_w[2] = if2.out;  assign busy_w[2] = if2.busy;  assign done_w[2] = if2.done;
  assign out_w[3] = if3.out;  assign busy_w[3] = if3.busy;  assign done_w[3] = if3.done;

  uart_tx_param #(.CLKS_PER_BIT(4)) dut0 (.clk(clk), .rst(rst), .tx(if0));
  uart_tx_param #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .rst(rst), .tx(if1));
  uart_tx_param #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .rst(rst), .tx(if2));
  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .tx(if3));

  logic o_s [1:100];
  logic b_s [1:100];
  logic d_s [1:100];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples one instance for ncyc cycles after an accept edge; events fire
  // right after sampling cycle c, i.e. they are seen by the following edge.
  task automatic capture(input int sel, input int ncyc, input int start_low_at,
                         input int en_low_at, input int rst_at, input int poke_at,
                         input int data_at, input logic [8:0] data_val);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o_s[c] = out_w[sel];
      b_s[c] = busy_w[sel];
      d_s[c] = done_w[sel];
      if (c == start_low_at) start_v[sel] = 1'b0;
      if (c == en_low_at)    en_v[sel]    = 1'b0;
      if (c == rst_at)       rst          = 1'b1;
      if (c == data_at)      data_v[sel]  = data_val;
      if (c == poke_at)      start_v[sel] = 1'b1;
      if (poke_at != 0 && c == poke_at + 1) start_v[sel] = 1'b0;
    end
  endtask

  task automatic check_bits(input string tag, input int nper, input logic [31:0] exp);
    for (int p = 0; p < nper; p++) begin
      logic [3:0] got;
      got = {o_s[4*p+4], o_s[4*p+3], o_s[4*p+2], o_s[4*p+1]};
      check($sformatf("%s_bit%0d", tag, p), {28'd0, got}, exp[p] ? 32'hF : 32'h0);
    end
  endtask

  task automatic check_ctl(input string tag, input int flen);
    int nb;
    int nd;
    nb = 0;
    nd = 0;
    for (int c = 1; c <= flen; c++) begin
      nb += int'(b_s[c]);
      nd += int'(d_s[c]);
    end
    check({tag, "_busy_cycles"}, nb, flen);
    check({tag, "_done_early"}, nd, 0);
    check({tag, "_end_bdo"}, {29'd0, b_s[flen+1], d_s[flen+1], o_s[flen+1]}, 32'h3);
  endtask

  task automatic launch(input int sel, input logic [8:0] d);
    start_v[sel] = 1'b1;
    data_v[sel]  = d;
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en_v[i] = 1'b0; start_v[i] = 1'b0; data_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_bdo0", {29'd0, busy_w[0], done_w[0], out_w[0]}, 32'h1);
    check("reset_bdo3", {29'd0, busy_w[3], done_w[3], out_w[3]}, 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) en_v[i] = 1'b1;
    @(negedge clk);
    check("idle_bdo0", {29'd0, busy_w[0], done_w[0], out_w[0]}, 32'h1);

    // 8N1 frame of A5: 0,1,0,1,0,0,1,0,1,1
    launch(0, 9'h0A5);
    capture(0, 44, 1, 0, 0, 0, 0, 9'h0);
    check_bits("a5", 10, 32'h34A);
    check_ctl("a5", 40);

    // Even parity of 07 is 1, odd parity is 0
    launch(1, 9'h007);
    capture(1, 48, 1, 0, 0, 0, 0, 9'h0);
    check_bits("par_even", 11, 32'h60E);
    check_ctl("par_even", 44);

    launch(2, 9'h007);
    capture(2, 48, 1, 0, 0, 0, 0, 9'h0);
    check_bits("par_odd", 11, 32'h40E);
    check_ctl("par_odd", 44);

    // 7 data bits, two stop bits
    launch(3, 9'h055);
    capture(3, 44, 1, 0, 0, 0, 0, 9'h0);
    check_bits("stop2", 10, 32'h3AA);
    check_ctl("stop2", 40);

    // Back-to-back: 01 then 80 with start held through the first frame
    launch(0, 9'h001);
    capture(0, 84, 45, 0, 0, 0, 1, 9'h080);
    check_bits("b2b", 20, 32'hC0202);
    nd = 0;
    for (int c = 1; c <= 84; c++) nd += int'(d_s[c]);
    check("b2b_done_count", nd, 2);
    check("b2b_done_pos", {30'd0, d_s[41], d_s[81]}, 32'h3);
    check("b2b_busy_gap", {30'd0, b_s[40], b_s[41]}, 32'h3);
    check("b2b_end_busy", {31'd0, b_s[81]}, 32'h0);

    // Abort during the third data bit (cycles 13..16)
    launch(0, 9'h000);
    capture(0, 24, 1, 14, 0, 0, 0, 9'h0);
    check("abort_before", {30'd0, b_s[14], o_s[14]}, 32'h2);
    check("abort_after", {30'd0, b_s[15], o_s[15]}, 32'h1);
    nd = 0;
    for (int c = 1; c <= 24; c++) nd += int'(d_s[c]);
    check("abort_no_done", nd, 0);
    en_v[0] = 1'b1;
    launch(0, 9'h03C);
    capture(0, 44, 1, 0, 0, 0, 0, 9'h0);
    check_bits("post_abort", 10, 32'h278);
    check_ctl("post_abort", 40);

    // Start pulse and new data mid-frame must not disturb the frame
    launch(0, 9'h0A5);
    capture(0, 44, 1, 0, 0, 10, 10, 9'h000);
    check_bits("busy_start", 10, 32'h34A);
    check_ctl("busy_start", 40);

    // Reset mid-data with start held high
    launch(0, 9'h000);
    capture(0, 12, 0, 0, 10, 0, 0, 9'h0);
    check("rst_before", {30'd0, b_s[10], o_s[10]}, 32'h2);
    check("rst_after", {29'd0, b_s[11], d_s[11], o_s[11]}, 32'h1);
    check("rst_held", {29'd0, b_s[12], d_s[12], o_s[12]}, 32'h1);
    rst = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    launch(0, 9'h0A5);
    capture(0, 44, 1, 0, 0, 0, 0, 9'h0);
    check_bits("post_rst", 10, 32'h34A);
    check_ctl("post_rst", 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
